timer_bank: RTL
===============

# timer_bank

Parametrised multi-channel timer peripheral with interrupt aggregation, mapped into the CPU's peripheral address space (address bit 30 set). It replaces the single fixed 32-bit timer with `N_CH` independent channels. Each channel has a configurable counter width, a prescaler, periodic or one-shot mode, and a per-channel interrupt enable. All channel interrupts are OR-reduced onto the single `irq` line that feeds the control unit's IRQ input.

## Interface
- `N_CH`, 4: number of timer channels, 1..8.
- `WIDTH`, 32: counter/reload width, 8..32.
- `PRESC_W`, 16: prescaler register width.
- `BASE_ADDR`, 32'h40000000: byte base address of the register window.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_rd`  in  1  bus read strobe (same cycle as `addr`).
- `mem_wr`  in  1  bus write strobe; write lands on the next `clk` edge.
- `addr`  in  32  byte address; `addr[1:0]` ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational.
- `hit`  out  1  `addr` decodes to a mapped register; used by the CPU read mux.
- `irq_vec`  out  N_CH  per-channel `ST & IE`.
- `irq`  out  1  `|irq_vec`.

## Operation
- Register map, per channel i, at `BASE_ADDR + 16*i`:
  - +0 TH: reload value.
  - +4 TL: counter.
  - +8 TCON:
    - [0] EN
    - [1] IE
    - [2] ST: status; write 1 to clear.
    - [3] OS: one-shot.
  - +C PRESC: prescaler.
- Global register at `BASE_ADDR + 0x80`: IRQ_STAT, read-only, `{0, irq_vec}`.
- Any other offset: `hit=0`, reads return 0, writes are ignored.
- Reads: `rdata` is the selected register zero-extended when `mem_rd & hit`, else 0. TH, TL and PRESC writes take the low WIDTH/PRESC_W bits.
- Prescaler: internal counter `pc` (PRESC_W bits, not visible on the bus).
  - While EN=1: `tick = (pc == PRESC)`; on tick `pc <= 0`, otherwise `pc <= pc+1`.
  - While EN=0: `pc` is held at 0.
  - PRESC=0 gives a tick every cycle.
- On tick:
  - If TL is all-ones: `TL <= TH`, `ST <= 1`, and if OS=1 also `EN <= 0`.
  - Otherwise: `TL <= TL+1` (modulo 2^WIDTH).
- Writing TCON with EN 0→1 resets `pc` to 0.

## Timing
- Reset values: TH, TL, TCON, PRESC, `pc` = 0; `irq=0`, `irq_vec=0`.
- `rdata` and `hit` are combinational. With no access they are 0, including during reset.
- Overflow latency: ST rises on the clock edge of the overflow tick. `irq_vec`/`irq` follow combinationally from the flops, i.e. they are valid in the cycle after that edge.
- Simultaneous events, same edge:
  - Bus write to TL vs tick: the write wins and no increment occurs.
  - Bus write to TCON vs tick: EN/IE/OS take the written values. If the tick overflows, ST is set regardless of the W1C bit (set beats clear, so no interrupt is lost).
  - One-shot overflow plus a write of EN=1: the written EN wins.
- TH written on the overflow edge: the old TH is reloaded.
- Reset mid-count: all state clears immediately and asynchronously; `irq` drops without waiting for a clock.

## Structure
- Shared package `timer_pkg`:
  - Register offsets TH/TL/TCON/PRESC/IRQ_STAT.
  - TCON bit indices EN/IE/ST/OS.
  - Channel stride constant 16.
- Sub-module `timer_channel` (parameters WIDTH, PRESC_W): holds the registers, prescaler and overflow logic, and takes its own write strobes. It is instantiated `N_CH` times by a generate loop.
- Top level contains only the address decode, read mux and IRQ reduction.

## Test plan
- **Reset values:** assert reset, then read every mapped register → all 0, `irq=0`. Read `BASE+0x90` → `hit=0`, `rdata=0`.
- **Periodic reload, ch0:** TH=FFFFFFFC, TL=FFFFFFFC, PRESC=0, TCON=0x3.
  - ST=1 and `irq=1` in the cycle after the 4th tick edge; TL=FFFFFFFC.
  - Writing TCON=0x7 clears ST and drops `irq`; counting continues.
- **Prescaler and one-shot, ch2, WIDTH=8:** TH=0, TL=FE, PRESC=3, TCON=0xB.
  - TL=FF after 4 cycles; overflow after 8 cycles.
  - ST=1, EN=0, TL=0, and TL stays 0 thereafter.
- **Collisions:**
  - Write TL=0x10 on the edge where a tick is due → TL reads 0x10.
  - W1C of ST on the edge of an overflow → ST remains 1.
- **Multi-channel aggregation, N_CH=4:** ch1 and ch3 overflow, but only ch3 has IE=1 → `irq_vec=4'b1000`, IRQ_STAT=0x8, `irq=1`.
- **Reset mid-count:** drop reset while ch0 is counting → TL=0 and `irq=0` asynchronously. After release, nothing counts until EN is written.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer bank: register offsets, TCON bit positions, channel stride.
package timer_pkg;

   localparam int unsigned CH_STRIDE = 16;

   localparam logic [31:0] OFF_TH       = 32'h00;
   localparam logic [31:0] OFF_TL       = 32'h04;
   localparam logic [31:0] OFF_TCON     = 32'h08;
   localparam logic [31:0] OFF_PRESC    = 32'h0C;
   localparam logic [31:0] OFF_IRQ_STAT = 32'h80;

   // Register select within a channel, taken from byte offset bits [3:2].
   typedef enum logic [1:0] {
      REG_TH    = OFF_TH[3:2],
      REG_TL    = OFF_TL[3:2],
      REG_TCON  = OFF_TCON[3:2],
      REG_PRESC = OFF_PRESC[3:2]
   } reg_sel_e;

   localparam int unsigned TCON_W  = 4;
   localparam int unsigned TCON_EN = 0;
   localparam int unsigned TCON_IE = 1;
   localparam int unsigned TCON_ST = 2;
   localparam int unsigned TCON_OS = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/counter/prescaler registers, prescaler and overflow logic.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_th_i,
   input  logic               wr_tl_i,
   input  logic               wr_tcon_i,
   input  logic               wr_presc_i,
   input  logic [31:0]        wdata_i,
   output logic [WIDTH-1:0]   th_o,
   output logic [WIDTH-1:0]   tl_o,
   output logic [TCON_W-1:0]  tcon_o,
   output logic [PRESC_W-1:0] presc_o
);

   logic [WIDTH-1:0]   th_q, th_d;
   logic [WIDTH-1:0]   tl_q, tl_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pc_q, pc_d;
   logic               en_q, en_d;
   logic               ie_q, ie_d;
   logic               st_q, st_d;
   logic               os_q, os_d;
   logic               tick;
   logic               ovf;
   logic               unused_wdata;

   assign tick = en_q && (pc_q == presc_q);
   assign ovf  = tick && (&tl_q);

   assign unused_wdata = ^wdata_i;

   // Next state: counting first, then bus writes override (write wins, except ST where set beats clear).
   always_comb begin
      th_d    = th_q;
      tl_d    = tl_q;
      presc_d = presc_q;
      pc_d    = pc_q;
      en_d    = en_q;
      ie_d    = ie_q;
      st_d    = st_q;
      os_d    = os_q;

      if (!en_q || tick) begin
         pc_d = '0;
      end else begin
         pc_d = pc_q + PRESC_W'(1);
      end

      if (tick) begin
         if (ovf) begin
            tl_d = th_q;
            st_d = 1'b1;
            if (os_q) begin
               en_d = 1'b0;
            end
         end else begin
            tl_d = tl_q + WIDTH'(1);
         end
      end

      if (wr_th_i) begin
         th_d = wdata_i[WIDTH-1:0];
      end
      if (wr_tl_i) begin
         tl_d = wdata_i[WIDTH-1:0];
      end
      if (wr_presc_i) begin
         presc_d = wdata_i[PRESC_W-1:0];
      end
      if (wr_tcon_i) begin
         en_d = wdata_i[TCON_EN];
         ie_d = wdata_i[TCON_IE];
         os_d = wdata_i[TCON_OS];
         if (wdata_i[TCON_ST] && !ovf) begin
            st_d = 1'b0;
         end
         // Enabling from idle starts a fresh prescale period; disabling parks pc at 0.
         if (!en_q || !wdata_i[TCON_EN]) begin
            pc_d = '0;
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         th_q    <= '0;
         tl_q    <= '0;
         presc_q <= '0;
         pc_q    <= '0;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         st_q    <= 1'b0;
         os_q    <= 1'b0;
      end else begin
         th_q    <= th_d;
         tl_q    <= tl_d;
         presc_q <= presc_d;
         pc_q    <= pc_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         st_q    <= st_d;
         os_q    <= os_d;
      end
   end

   // Register view for the bus.
   always_comb begin
      tcon_o          = '0;
      tcon_o[TCON_EN] = en_q;
      tcon_o[TCON_IE] = ie_q;
      tcon_o[TCON_ST] = st_q;
      tcon_o[TCON_OS] = os_q;
   end

   assign th_o    = th_q;
   assign tl_o    = tl_q;
   assign presc_o = presc_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer peripheral: address decode, read mux and interrupt aggregation.
module timer_bank
   import timer_pkg::*;
#(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned PRESC_W   = 16,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            hit,
   output logic [N_CH-1:0] irq_vec,
   output logic            irq
);

   logic [31:0]        off;
   logic [2:0]         ch_idx;
   reg_sel_e           reg_sel;
   logic               ch_hit;
   logic               stat_hit;

   logic [WIDTH-1:0]   th    [N_CH];
   logic [WIDTH-1:0]   tl    [N_CH];
   logic [TCON_W-1:0]  tcon  [N_CH];
   logic [PRESC_W-1:0] presc [N_CH];

   assign off      = addr - BASE_ADDR;
   assign ch_idx   = off[6:4];
   assign reg_sel  = reg_sel_e'(off[3:2]);
   assign ch_hit   = (off < 32'(CH_STRIDE * N_CH));
   assign stat_hit = (off[31:2] == OFF_IRQ_STAT[31:2]);
   assign hit      = (mem_rd | mem_wr) & (ch_hit | stat_hit);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic wr_sel;
      assign wr_sel = mem_wr && ch_hit && (ch_idx == 3'(g));

      timer_channel #(
         .WIDTH   (WIDTH),
         .PRESC_W (PRESC_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (reset),
         .wr_th_i    (wr_sel && (reg_sel == REG_TH)),
         .wr_tl_i    (wr_sel && (reg_sel == REG_TL)),
         .wr_tcon_i  (wr_sel && (reg_sel == REG_TCON)),
         .wr_presc_i (wr_sel && (reg_sel == REG_PRESC)),
         .wdata_i    (wdata),
         .th_o       (th[g]),
         .tl_o       (tl[g]),
         .tcon_o     (tcon[g]),
         .presc_o    (presc[g])
      );
   end

   // Per-channel interrupt = status gated by enable; single OR-reduced line to the CPU.
   always_comb begin
      irq_vec = '0;
      for (int i = 0; i < N_CH; i++) begin
         irq_vec[i] = tcon[i][TCON_ST] & tcon[i][TCON_IE];
      end
   end

   assign irq = |irq_vec;

   // Read mux, zero-extended; 0 unless a mapped register is being read.
   always_comb begin
      rdata = '0;
      if (mem_rd && hit) begin
         if (stat_hit) begin
            rdata = 32'(irq_vec);
         end else begin
            for (int i = 0; i < N_CH; i++) begin
               if (ch_idx == 3'(i)) begin
                  case (reg_sel)
                     REG_TH:    rdata = 32'(th[i]);
                     REG_TL:    rdata = 32'(tl[i]);
                     REG_TCON:  rdata = 32'(tcon[i]);
                     REG_PRESC: rdata = 32'(presc[i]);
                     default:   rdata = '0;
                  endcase
               end
            end
         end
      end
   end

endmodule
